// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by the ALU controller and the
// multiply/divide sequencer, plus the sequencer state encoding.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_NOP  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd11;
    localparam logic [ALU_OP_W-1:0] ALU_MULT = 4'd12;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 4'd13;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_CALC  = 2'd1,
        MD_FIXUP = 2'd2,
        MD_DONE  = 2'd3
    } md_state_t;

    // True for the operation codes the multiply/divide sequencer acts upon.
    function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step_unit.sv
// Iterative unsigned radix-2 datapath for the multiply/divide sequencer.
// Ports:
//   clk, rst_b   clock, synchronous active-low reset
//   load         capture mag_a into the low half of acc and mag_b as the operand
//   step         perform one radix-2 step (shift-add or restoring shift-subtract)
//   is_div       selects divide stepping (1) or multiply stepping (0)
//   mag_a, mag_b operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc          {upper, lower}: product, or {remainder, quotient} after XLEN steps
module muldiv_step_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    output logic [2*XLEN-1:0] acc
);

    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] acc_nxt;

    // One radix-2 step. The remainder stays below the divisor, so the
    // subtraction result always fits in XLEN bits when it is kept.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        rem_ge  = (rem_sh >= {1'b0, opnd});
        diff    = rem_sh[XLEN-1:0] - opnd;
        acc_nxt = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (rem_ge) begin
                acc_nxt = {diff, acc[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

    // Accumulator and held operand.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{XLEN{1'b0}}, mag_a};
            opnd <= mag_b;
        end else if (step) begin
            acc  <= acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer owning the architectural HI/LO pair.
// Ports:
//   clk, rst_b          clock, synchronous active-low reset
//   start, alu_operation request; only MULT and DIV are accepted, in IDLE
//   operand_a, operand_b rs (multiplicand/dividend), rt (multiplier/divisor)
//   flush               abandon an operation in CALC or FIXUP
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured in IDLE only
//   busy                stall request, high whenever not IDLE
//   done                one-cycle result-valid pulse
//   div_zero            last DIV had a zero divisor
//   hi, lo              architectural HI/LO registers
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [3:0]      alu_operation,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic              op_div;
    logic              sign_a;
    logic              sign_b;

    logic              accept_c;
    logic              div_req_c;
    logic              div_zero_req_c;
    logic              load_c;
    logic              step_c;
    logic [XLEN-1:0]   mag_a_c;
    logic [XLEN-1:0]   mag_b_c;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   res_hi_c;
    logic [XLEN-1:0]   res_lo_c;

    // Request decode and operand magnitudes (-2^(XLEN-1) maps to 2^(XLEN-1) unsigned).
    always_comb begin
        accept_c       = (state == MD_IDLE) && start && is_muldiv(alu_operation);
        div_req_c      = (alu_operation == ALU_DIV);
        div_zero_req_c = div_req_c && (operand_b == '0);
        load_c         = accept_c && !div_zero_req_c;
        step_c         = (state == MD_CALC) && !flush;
        mag_a_c        = operand_a[XLEN-1] ? -operand_a : operand_a;
        mag_b_c        = operand_b[XLEN-1] ? -operand_b : operand_b;
    end

    muldiv_step_unit #(
        .XLEN   (XLEN)
    ) u_step (
        .clk    (clk),
        .rst_b  (rst_b),
        .load   (load_c),
        .step   (step_c),
        .is_div (op_div),
        .mag_a  (mag_a_c),
        .mag_b  (mag_b_c),
        .acc    (acc)
    );

    // Sign fixup: product negated on differing signs; quotient truncates toward
    // zero, remainder follows the dividend. -2^31/-1 wraps naturally to 2^31.
    always_comb begin
        prod_c   = (sign_a ^ sign_b) ? -acc : acc;
        res_hi_c = prod_c[2*XLEN-1:XLEN];
        res_lo_c = prod_c[XLEN-1:0];
        if (op_div) begin
            res_lo_c = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            res_hi_c = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end
    end

    // Sequencer FSM, iteration counter and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state    <= MD_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            op_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    // MTHI/MTLO first so a same-edge result takes precedence.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept_c) begin
                        op_div <= div_req_c;
                        sign_a <= operand_a[XLEN-1];
                        sign_b <= operand_b[XLEN-1];
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (div_zero_req_c) begin
                            state    <= MD_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            hi       <= operand_a;
                            lo       <= '1;
                        end else begin
                            state    <= MD_CALC;
                            div_zero <= 1'b0;
                        end
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) state <= MD_FIXUP;
                    end
                end
                MD_FIXUP: begin
                    if (flush) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hi    <= res_hi_c;
                        lo    <= res_lo_c;
                        done  <= 1'b1;
                        state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [3:0]  alu_operation;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_MULT = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .start         (start),
        .alu_operation (alu_operation),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .flush         (flush),
        .hi_we         (hi_we),
        .lo_we         (lo_we),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .div_zero      (div_zero),
        .hi            (hi),
        .lo            (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one op at the current negedge; observe until busy drops (bounded).
    // done_k is the negedge index after E0 where done was seen (E33..E34 -> 34).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int done_k, output int done_n, output int busy_n);
        start = 1'b1; alu_operation = op; operand_a = a; operand_b = b;
        @(posedge clk);
        #1 start = 1'b0; alu_operation = 4'd0;
        done_k = 0; done_n = 0; busy_n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (!busy) break;
        end
    endtask

    int dk, dn, bn;

    initial begin
        vecs[0]  = '{OP_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[2]  = '{OP_DIV,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[3]  = '{OP_MULT, 32'd5,          32'd6,         32'd0,         32'd30,        1'b0, 34};
        vecs[4]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34};
        vecs[5]  = '{OP_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 34};
        vecs[6]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34};
        vecs[7]  = '{OP_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 34};
        vecs[8]  = '{OP_DIV,  32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 34};
        vecs[9]  = '{OP_MULT, 32'h1234_5678,  32'h10,        32'd1,         32'h2345_6780, 1'b0, 34};
        vecs[10] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0, 34};
        vecs[11] = '{OP_DIV,  32'd0,          32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[12] = '{OP_MULT, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 34};

        rst_b = 1'b0; start = 1'b0; alu_operation = 4'd0; operand_a = '0; operand_b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz",   64'(div_zero), 64'd0);
        check("rst_hi",   64'(hi), 64'd0);
        check("rst_lo",   64'(lo), 64'd0);

        // First start on the first edge with rst_b high
        rst_b = 1'b1;
        run_op(OP_MULT, 32'd2, 32'd3, dk, dn, bn);
        check("first_lat", 64'(dk), 64'd34);
        check("first_lo",  64'(lo), 64'd6);

        // Table-driven operations
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dk, dn, bn);
            check($sformatf("v%0d_hi", i),    64'(hi),       64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i),    64'(lo),       64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dz", i),    64'(div_zero), 64'(vecs[i].exp_dz));
            check($sformatf("v%0d_lat", i),   64'(dk),       64'(vecs[i].exp_lat));
            check($sformatf("v%0d_ndone", i), 64'(dn),       64'd1);
            check($sformatf("v%0d_busy", i),  64'(bn),       64'(vecs[i].exp_lat));
        end

        // Ignored opcode
        start = 1'b1; alu_operation = OP_ADD; operand_a = 32'd1; operand_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        check("add_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("add_done", 64'(done), 64'd0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", 64'(hi), 64'h1234);
        check("mtlo", 64'(lo), 64'h5678);

        // Flush at E10 of a MULT, with an MTHI attempt while busy
        start = 1'b1; alu_operation = OP_MULT; operand_a = 32'd9; operand_b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) begin hi_we = 1'b1; wdata = 32'hDEAD; end
            if (k == 4) hi_we = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("flush_ndone", 64'(dn), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234);
        check("flush_lo", 64'(lo), 64'h5678);

        // Start while busy at E5 is ignored
        start = 1'b1; alu_operation = OP_DIV; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        dk = 0; dn = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) begin start = 1'b1; alu_operation = OP_MULT; operand_a = 32'd3; operand_b = 32'd3; end
            if (k == 6) start = 1'b0;
            if (done) begin dn++; if (dk == 0) dk = k; end
            if (!busy) break;
        end
        check("bsy_lat", 64'(dk), 64'd34);
        check("bsy_nd",  64'(dn), 64'd1);
        check("bsy_hi",  64'(hi), 64'd2);
        check("bsy_lo",  64'(lo), 64'd14);
        repeat (3) @(negedge clk);
        check("bsy_noqueue", 64'(busy), 64'd0);

        // MTHI together with an accepted start: result wins
        hi_we = 1'b1; wdata = 32'hAAAA;
        run_op(OP_MULT, 32'd4, 32'd5, dk, dn, bn);
        hi_we = 1'b0;
        check("mthi_start_hi", 64'(hi), 64'd0);
        check("mthi_start_lo", 64'(lo), 64'd20);

        // Reset at E20 of a DIV
        start = 1'b1; alu_operation = OP_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 20) rst_b = 1'b0;
        end
        @(negedge clk);
        check("rst20_busy", 64'(busy), 64'd0);
        check("rst20_hi",   64'(hi), 64'd0);
        check("rst20_lo",   64'(lo), 64'd0);
        rst_b = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst20_ndone", 64'(dn), 64'd0);

        // Divide-by-zero then a MULT clears div_zero
        run_op(OP_DIV, 32'd5, 32'd0, dk, dn, bn);
        check("dz_flag", 64'(div_zero), 64'd1);
        start = 1'b1; alu_operation = OP_MULT; operand_a = 32'd1; operand_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        check("dz_clear", 64'(div_zero), 64'd0);
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
